// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: default widths and master indices.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 30;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick2.sv
// Combinational two-way picker: a lone eligible master wins; ties go round-robin against
// 'last', or always to m0 when fixed_pri is set.
module arb_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last,
    input  logic       fixed_pri,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |elig;
        pick  = M0;
        unique case (elig)
            2'b01:   pick = M0;
            2'b10:   pick = M1;
            2'b11:   pick = fixed_pri ? M0 : ~last;
            default: pick = M0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port one-cycle-latency RAM with pipelined issue.
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed m0-wins tie-break (no 'last' register).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    localparam int unsigned NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_re,
    input  logic [NB-1:0]     m0_we,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_re,
    input  logic [NB-1:0]     m1_we,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic [NB-1:0]     ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic       busy_q;
    logic       owner_q;
    logic       last_q;
    logic       req0;
    logic       req1;
    logic [1:0] elig;
    logic       pick_valid;
    logic       pick;
    logic       issue;
    logic       fixed_pri;

    assign req0 = m0_re | (|m0_we);
    assign req1 = m1_re | (|m1_we);

    // The in-flight master keeps its request up until ready; never reissue it.
    assign elig[0] = req0 & ~(busy_q & (owner_q == M0));
    assign elig[1] = req1 & ~(busy_q & (owner_q == M1));

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    assign fixed_pri = 1'b1;
    assign last_q    = 1'b0;
`else
    assign fixed_pri = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= M1;
        end else if (pick_valid) begin
            last_q <= pick;
        end
    end
`endif

    arb_pick2 u_pick (
        .elig      (elig),
        .last      (last_q),
        .fixed_pri (fixed_pri),
        .valid     (pick_valid),
        .pick      (pick)
    );

    // Issue is combinational from requests, so hold the RAM quiet while reset is asserted.
    assign issue = pick_valid & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            owner_q <= M0;
        end else begin
            busy_q <= pick_valid;
            if (pick_valid) begin
                owner_q <= pick;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_we    = '0;
        if (issue) begin
            if (pick == M1) begin
                ram_addr  = m1_addr;
                ram_wdata = m1_wdata;
                ram_re    = m1_re;
                ram_we    = m1_we;
            end else begin
                ram_addr  = m0_addr;
                ram_wdata = m0_wdata;
                ram_re    = m0_re;
                ram_we    = m0_we;
            end
        end
    end

    assign m0_ready = busy_q & (owner_q == M0);
    assign m1_ready = busy_q & (owner_q == M1);
    assign m0_rdata = ram_rdata;
    assign m1_rdata = ram_rdata;

endmodule
